div_iter_16: RTL
================

DIV_ITER_16 -- requirements
Module: div_iter_16

Interface
REQ-001 SHALL have one clock: clk, rising-edge; reset rst, synchronous, active-high.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  request a divide; sampled only in IDLE.
REQ-005 dividend  in  32  unsigned dividend (DX:AX); DX = dividend[31:16].
REQ-006 divisor  in  16  unsigned divisor (r/m16 operand).
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 quot  out  16  quotient (to AX).
REQ-010 rem  out  16  remainder (to DX).
REQ-011 div_err  out  1  divide error (8088 type-0 trap request); valid while done=1.

Function
REQ-012 SHALL perform unsigned 32/16 restoring division, one quotient bit per clock, using one 16-bit subtract row (17-bit minuend, borrow out) per iteration.
REQ-013 SHALL implement FSM states IDLE, CHECK, CALC, DONE.
REQ-014 IDLE: on clk edge with start=1, SHALL latch dividend and divisor, go to CHECK; start=0 stays IDLE.
REQ-015 CHECK: if dividend[31:16] >= divisor (covers divisor=0), SHALL set div_err=1 and go to DONE; else load partial remainder R=dividend[31:16], clear iteration counter, clear div_err, go to CALC.
REQ-016 CALC iteration k (k=0..15) SHALL form P={R, dividend[15-k]} (17 bits), compute D=P-{1'b0,divisor}; if P>=divisor then R=D[15:0], quotient bit 15-k=1; else R=P[15:0], bit=0.
REQ-017 CALC SHALL run exactly 16 iterations; the edge completing k=15 SHALL write quot and rem and go to DONE.
REQ-018 DONE: done=1 for exactly one cycle; next edge to IDLE unconditionally.
REQ-019 Latency: with start sampled at edge E0, normal path SHALL enter DONE at edge E0+17; error path SHALL enter DONE at edge E0+2.
REQ-020 On error, quot and rem SHALL hold their previous values.
REQ-021 quot/rem SHALL hold their last written values in IDLE until the next successful divide completes.
REQ-022 start while busy (CHECK, CALC, DONE) SHALL be ignored; no queuing.
REQ-023 Operand inputs SHALL be ignored after the latching edge; changes mid-operation do not affect results.
REQ-024 Invariant: R < divisor at every iteration boundary; the 17-bit partial never overflows.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, busy=0, done=0, div_err=0, quot=0x0000, rem=0x0000, counter=0, regardless of state.
REQ-026 Reset mid-CALC SHALL abort the operation with no done pulse; a start after rst deasserts SHALL run normally.
REQ-027 rst SHALL take priority over start in the same cycle.

Verification
REQ-028 dividend=0x0001_0000, divisor=0x0002 -> quot=0x8000, rem=0x0000, div_err=0, done exactly 18 cycles after start was sampled (enters DONE at E0+17).
REQ-029 dividend=0x0000_0007, divisor=0x0003 -> quot=0x0002, rem=0x0001; then dividend=0xFFFE_FFFF, divisor=0xFFFF -> quot=0xFFFF, rem=0xFFFE.
REQ-030 divisor=0x0000 (any dividend), and dividend=0x0002_0000 with divisor=0x0002 -> div_err=1, done at E0+2, quot/rem unchanged from the prior result.
REQ-031 start pulsed again during CALC with different operands -> ignored; the first result is delivered unchanged with a single done pulse.
REQ-032 rst asserted at iteration k=8 -> next cycle busy=0, quot=rem=0, no done; a following 0x0000_0064/0x000A divide -> quot=0x000A, rem=0x0000.
REQ-033 Randomized: 10k operand pairs checked against a reference model (quot=floor(N/d), rem=N mod d, error iff N[31:16]>=d); assert busy/done protocol every cycle.

Source files
------------

// File: rtl/div_iter_16.sv
// Purpose : unsigned 32/16 restoring divider (8088 DIV r/m16), one quotient bit per clock.
// Latency : start sampled at edge E0 -> DONE entered at E0+17 (normal) or E0+2 (divide error).
// Backpres: none; start is only accepted in IDLE, requests while busy are dropped (no queuing).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               divide request, sampled only in IDLE
//   dividend[31:0]      DX:AX, unsigned
//   divisor[15:0]       r/m16 operand, unsigned
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse (state DONE)
//   quot[15:0]          quotient (AX), held until the next successful divide
//   rem[15:0]           remainder (DX), held until the next successful divide
//   div_err             divide error (type-0 trap request), valid while done=1
module div_iter_16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [15:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [15:0] quot,
   output logic [15:0] rem,
   output logic        div_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_CALC  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [15:0] r_hi;       // latched dividend[31:16]
   logic [15:0] r_lo;       // latched dividend[15:0], shifted left one bit per iteration
   logic [15:0] r_dvs;      // latched divisor
   logic [15:0] r_part;     // partial remainder R
   logic [15:0] r_qacc;     // quotient bits accumulated MSB first
   logic [3:0]  r_cnt;      // iteration index k
   logic        r_div_err;
   logic [15:0] r_quot;
   logic [15:0] r_rem;

   logic [16:0] w_p;        // {R, next dividend bit}
   logic [17:0] w_diff;     // P - divisor, bit 17 is the borrow
   logic        w_ge;
   logic [15:0] w_r_next;
   logic        w_ovf;

   // One subtract row. R < divisor on entry, so P < 2*divisor and the
   // restored/subtracted result always fits back into 16 bits.
   assign w_p      = {r_part, r_lo[15]};
   assign w_diff   = {1'b0, w_p} - {2'b00, r_dvs};
   assign w_ge     = ~w_diff[17];
   assign w_r_next = w_ge ? w_diff[15:0] : w_p[15:0];

   // Quotient would not fit in 16 bits; divisor == 0 is caught here too.
   assign w_ovf    = (r_hi >= r_dvs);

   assign quot     = r_quot;
   assign rem      = r_rem;
   assign div_err  = r_div_err;

   always_comb begin
      w_next = r_state;
      busy   = 1'b1;
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_next = S_CHECK;
         end
         S_CHECK: begin
            // The error flag is registered for one cycle before DONE so the
            // trap request always arrives two edges after start was taken.
            if (r_div_err)  w_next = S_DONE;
            else if (!w_ovf) w_next = S_CALC;
         end
         S_CALC: begin
            if (r_cnt == 4'd15) w_next = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_hi      <= 16'h0000;
         r_lo      <= 16'h0000;
         r_dvs     <= 16'h0000;
         r_part    <= 16'h0000;
         r_qacc    <= 16'h0000;
         r_cnt     <= 4'd0;
         r_div_err <= 1'b0;
         r_quot    <= 16'h0000;
         r_rem     <= 16'h0000;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_hi      <= dividend[31:16];
                  r_lo      <= dividend[15:0];
                  r_dvs     <= divisor;
                  r_div_err <= 1'b0;
               end
            end
            S_CHECK: begin
               if (!r_div_err) begin
                  if (w_ovf) begin
                     r_div_err <= 1'b1;
                  end else begin
                     r_part <= r_hi;
                     r_qacc <= 16'h0000;
                     r_cnt  <= 4'd0;
                  end
               end
            end
            S_CALC: begin
               r_part <= w_r_next;
               r_lo   <= {r_lo[14:0], 1'b0};
               r_qacc <= {r_qacc[14:0], w_ge};
               r_cnt  <= r_cnt + 4'd1;
               if (r_cnt == 4'd15) begin
                  r_quot <= {r_qacc[14:0], w_ge};
                  r_rem  <= w_r_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
